// File: rtl/dma_wr_arbiter.sv
// Round-robin arbiter sharing one DMA write master among N_REQ write-back producers.
// One transfer in flight: grant, issue the command, stream the grantee's data, route done/error back.
module dma_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int AXI_DATA_W = 128,
  parameter int AXI_ADDR_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*AXI_ADDR_W-1:0] req_addr,
  input  logic [N_REQ*24-1:0]         req_len,
  input  logic [N_REQ-1:0]            req_data_valid,
  output logic [N_REQ-1:0]            req_data_ready,
  input  logic [N_REQ*AXI_DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]            req_data_last,
  output logic [N_REQ-1:0]            req_done,
  output logic [N_REQ-1:0]            req_error,
  output logic                        dma_cmd_valid,
  input  logic                        dma_cmd_ready,
  output logic [AXI_ADDR_W-1:0]       dma_cmd_addr,
  output logic [23:0]                 dma_cmd_len,
  output logic [3:0]                  dma_cmd_tag,
  output logic                        dma_data_valid,
  input  logic                        dma_data_ready,
  output logic [AXI_DATA_W-1:0]       dma_data,
  output logic                        dma_data_last,
  input  logic                        dma_done,
  input  logic                        dma_error,
  output logic [2:0]                  grant_id,
  output logic                        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM} state_t;

  state_t     state;
  logic [2:0] rr_ptr;
  logic [2:0] winner;
  logic       win_found;
  logic [3:0] scan_idx;

  // Search rr_ptr, rr_ptr+1, ... wrapping at N_REQ; first valid requester wins.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + 4'(k);
      if (scan_idx >= 4'(N_REQ))
        scan_idx = scan_idx - 4'(N_REQ);
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!win_found && scan_idx == 4'(i) && req_valid[i]) begin
          win_found = 1'b1;
          winner    = 3'(i);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      req_ready[i] = rst_n && (state == S_IDLE) && win_found && (winner == 3'(i));
  end

  always_comb begin
    dma_data_valid = 1'b0;
    dma_data       = '0;
    dma_data_last  = 1'b0;
    req_data_ready = '0;
    if (state == S_STREAM) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (grant_id == 3'(i)) begin
          dma_data_valid    = req_data_valid[i];
          dma_data          = req_data[i*AXI_DATA_W +: AXI_DATA_W];
          dma_data_last     = req_data_last[i];
          req_data_ready[i] = dma_data_ready;
        end
      end
    end
  end

  assign busy        = (state != S_IDLE);
  assign dma_cmd_tag = {1'b0, grant_id};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      dma_cmd_valid <= 1'b0;
      dma_cmd_addr  <= '0;
      dma_cmd_len   <= '0;
      req_done      <= '0;
      req_error     <= '0;
    end else begin
      req_done  <= '0;
      req_error <= '0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant_id      <= winner;
            rr_ptr        <= (winner == 3'(N_REQ-1)) ? 3'd0 : winner + 3'd1;
            dma_cmd_valid <= 1'b1;
            state         <= S_ISSUE;
            for (int unsigned i = 0; i < N_REQ; i++) begin
              if (winner == 3'(i)) begin
                dma_cmd_addr <= req_addr[i*AXI_ADDR_W +: AXI_ADDR_W];
                dma_cmd_len  <= req_len[i*24 +: 24];
              end
            end
          end
        end
        S_ISSUE: begin
          if (dma_cmd_ready) begin
            dma_cmd_valid <= 1'b0;
            state         <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (dma_done) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
              if (grant_id == 3'(i)) begin
                req_done[i]  <= 1'b1;
                req_error[i] <= dma_error;
              end
            end
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_wr_arbiter.sv
// Directed bench for dma_wr_arbiter: a table of transfers with hand-computed grantees,
// plus a hand-written mid-stream reset sequence.
module tb_dma_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*24-1:0] req_len;
  logic [N-1:0]    req_data_valid;
  logic [N-1:0]    req_data_ready;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_data_last;
  logic [N-1:0]    req_done;
  logic [N-1:0]    req_error;
  logic            dma_cmd_valid;
  logic            dma_cmd_ready;
  logic [AW-1:0]   dma_cmd_addr;
  logic [23:0]     dma_cmd_len;
  logic [3:0]      dma_cmd_tag;
  logic            dma_data_valid;
  logic            dma_data_ready;
  logic [DW-1:0]   dma_data;
  logic            dma_data_last;
  logic            dma_done;
  logic            dma_error;
  logic [2:0]      grant_id;
  logic            busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dma_wr_arbiter #(.N_REQ(N), .AXI_DATA_W(DW), .AXI_ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .req_data_valid(req_data_valid), .req_data_ready(req_data_ready),
    .req_data(req_data), .req_data_last(req_data_last),
    .req_done(req_done), .req_error(req_error),
    .dma_cmd_valid(dma_cmd_valid), .dma_cmd_ready(dma_cmd_ready),
    .dma_cmd_addr(dma_cmd_addr), .dma_cmd_len(dma_cmd_len), .dma_cmd_tag(dma_cmd_tag),
    .dma_data_valid(dma_data_valid), .dma_data_ready(dma_data_ready),
    .dma_data(dma_data), .dma_data_last(dma_data_last),
    .dma_done(dma_done), .dma_error(dma_error),
    .grant_id(grant_id), .busy(busy)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [23:0] len;
    bit          err;
    int          cmd_wait;
    bit          stall;
    int          exp_g;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] beat(input int g, input int b);
    logic [31:0] w;
    w = 32'hA500_0000 | (32'(g) << 8) | 32'(b);
    return {4{w}};
  endfunction

  task automatic run_xfer(input vec_t v);
    int n, b, cyc;
    logic rdy;
    n = (int'(v.len) + 15) / 16;
    req_valid = v.mask;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = v.addr + 32'(i) * 32'h100;
      req_len[i*24 +: 24]  = (i == v.exp_g) ? v.len : v.len + 24'd1;
    end
    #1;
    chk("req_ready_onehot", req_ready, 4'b1 << v.exp_g);
    chk("idle_busy", busy, 0);
    tick();
    req_valid[v.exp_g] = 1'b0;
    chk("issue_cmd_valid", dma_cmd_valid, 1);
    chk("issue_addr", dma_cmd_addr, v.addr + 32'(v.exp_g) * 32'h100);
    chk("issue_len", dma_cmd_len, v.len);
    chk("issue_tag", dma_cmd_tag, v.exp_g);
    chk("grant_id", grant_id, v.exp_g);
    chk("issue_busy", busy, 1);
    chk("issue_req_ready", req_ready, 0);
    chk("issue_no_data_valid", dma_data_valid, 0);
    chk("done_one_cycle", req_done, 0);
    for (int w = 0; w < v.cmd_wait; w++) begin
      tick();
      chk("cmd_valid_held", dma_cmd_valid, 1);
    end
    dma_cmd_ready = 1'b1;
    tick();
    dma_cmd_ready = 1'b0;
    chk("stream_cmd_valid_low", dma_cmd_valid, 0);
    b = 0;
    cyc = 0;
    while (b < n && cyc < 200) begin
      for (int i = 0; i < N; i++) begin
        req_data_valid[i]       = 1'b1;
        req_data[i*DW +: DW]    = (i == v.exp_g) ? beat(i, b) : ~beat(i, b);
        req_data_last[i]        = (i == v.exp_g) ? (b == n - 1) : 1'b1;
      end
      rdy = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      dma_data_ready = rdy;
      #1;
      chk("beat_valid", dma_data_valid, 1);
      chk("beat_data", dma_data, beat(v.exp_g, b));
      chk("beat_last", dma_data_last, (b == n - 1));
      chk("beat_data_ready", req_data_ready, rdy ? (4'b1 << v.exp_g) : 4'b0);
      if (rdy) b++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (b < n) begin
      errors++;
      $display("FAIL beat_timeout: got %0d beats expected %0d", b, n);
    end
    req_data_valid = ~(4'b1 << v.exp_g);
    dma_data_ready = 1'b1;
    dma_done  = 1'b1;
    dma_error = v.err;
    #1;
    chk("grantee_idle_no_valid", dma_data_valid, 0);
    chk("only_grantee_ready", req_data_ready, 4'b1 << v.exp_g);
    tick();
    dma_done       = 1'b0;
    dma_error      = 1'b0;
    req_data_valid = '0;
    dma_data_ready = 1'b0;
    chk("done_routed", req_done, 4'b1 << v.exp_g);
    chk("error_routed", req_error, v.err ? (4'b1 << v.exp_g) : 4'b0);
    chk("done_busy", busy, 0);
  endtask

  initial begin
    vecs[0]  = '{mask:4'hF, addr:32'h2000, len:24'd16, err:0, cmd_wait:0, stall:0, exp_g:0};
    vecs[1]  = '{mask:4'hF, addr:32'h2000, len:24'd16, err:0, cmd_wait:2, stall:0, exp_g:1};
    vecs[2]  = '{mask:4'hF, addr:32'h2000, len:24'd16, err:0, cmd_wait:0, stall:0, exp_g:2};
    vecs[3]  = '{mask:4'hF, addr:32'h2000, len:24'd16, err:0, cmd_wait:0, stall:0, exp_g:3};
    vecs[4]  = '{mask:4'hF, addr:32'h2000, len:24'd16, err:0, cmd_wait:0, stall:0, exp_g:0};
    vecs[5]  = '{mask:4'h4, addr:32'h0E00, len:24'd64, err:0, cmd_wait:0, stall:0, exp_g:2};
    vecs[6]  = '{mask:4'h2, addr:32'h3000, len:24'd32, err:1, cmd_wait:1, stall:0, exp_g:1};
    vecs[7]  = '{mask:4'h2, addr:32'h3000, len:24'd32, err:0, cmd_wait:0, stall:0, exp_g:1};
    vecs[8]  = '{mask:4'h8, addr:32'h4000, len:24'd0,  err:0, cmd_wait:0, stall:0, exp_g:3};
    vecs[9]  = '{mask:4'h2, addr:32'h5000, len:24'd64, err:0, cmd_wait:0, stall:1, exp_g:1};
    vecs[10] = '{mask:4'h9, addr:32'h6000, len:24'd16, err:0, cmd_wait:0, stall:0, exp_g:3};
    vecs[11] = '{mask:4'h9, addr:32'h6000, len:24'd16, err:0, cmd_wait:0, stall:0, exp_g:0};

    rst_n = 1'b0;
    req_valid = '0; req_addr = '0; req_len = '0;
    req_data_valid = '0; req_data = '0; req_data_last = '0;
    dma_cmd_ready = 1'b0; dma_data_ready = 1'b0; dma_done = 1'b0; dma_error = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_valid", dma_cmd_valid, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_done", req_done, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 12; k++)
      run_xfer(vecs[k]);

    // Mid-stream reset: req2 granted (rr_ptr moves to 3), then reset while streaming.
    req_valid = 4'h4;
    tick();
    req_valid = '0;
    dma_cmd_ready = 1'b1;
    tick();
    dma_cmd_ready = 1'b0;
    req_data_valid = 4'h4;
    req_data[2*DW +: DW] = beat(2, 0);
    dma_data_ready = 1'b1;
    #1;
    chk("pre_rst_streaming", dma_data_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data_valid", dma_data_valid, 0);
    chk("mid_rst_data_ready", req_data_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_valid", dma_cmd_valid, 0);
    chk("mid_rst_grant_id", grant_id, 0);
    chk("mid_rst_done", req_done, 0);
    tick();
    rst_n = 1'b1;
    req_data_valid = '0;
    dma_data_ready = 1'b0;
    tick();
    chk("post_rst_no_done", req_done, 0);
    chk("post_rst_busy", busy, 0);
    run_xfer('{mask:4'hF, addr:32'h7000, len:24'd16, err:0, cmd_wait:0, stall:0, exp_g:0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
